// File: rtl/four_digit_display_driver.sv
// four_digit_display_driver
//
// Purpose:
//   Drives a 4-digit common-anode 7-segment display from four hex
//   characters. The characters are snapshotted into shadow registers once
//   per refresh frame, so the upstream scroller can update them at any time
//   without tearing. The digits are time-multiplexed leftmost first
//   (3, 2, 1, 0). Each digit slot begins with a blanking interval that
//   suppresses ghosting while the anode switches.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   char_an0   in   [3:0] hex char for anode 0 (rightmost)
//   char_an1   in   [3:0] hex char for anode 1
//   char_an2   in   [3:0] hex char for anode 2
//   char_an3   in   [3:0] hex char for anode 3 (leftmost)
//   an         out  [3:0] anode enables, active low
//   seg        out  [6:0] segments {a..g}, active low
//   frame_tick out  one-cycle pulse when the shadow registers load
//
// Optional feature (macro DISPLAY_DP_EN):
//   dp_in      in   [3:0] decimal point request per digit (1 = lit)
//   dp         out  decimal point, active low
//
// Parameters:
//   DIGIT_CYCLES  cycles per digit slot (blank + on), > DEAD_CYCLES
//   DEAD_CYCLES   blanking cycles at the start of each slot, >= 1
//   CNT_W         slot counter width, 2^CNT_W >= DIGIT_CYCLES

module four_digit_display_driver #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int DEAD_CYCLES  = 500,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] char_an0,
  input  logic [3:0] char_an1,
  input  logic [3:0] char_an2,
  input  logic [3:0] char_an3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_tick
`ifdef DISPLAY_DP_EN
  ,
  input  logic [3:0] dp_in,
  output logic       dp
`endif
);

  typedef enum logic {BLANK, ON} phase_t;

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       dig;
  phase_t           phase;
  logic [15:0]      shadow;
`ifdef DISPLAY_DP_EN
  logic [3:0]       dp_shadow;
`endif

  logic             frame_start;
  logic [3:0]       cur_char;

  // Hex to active-low {a,b,c,d,e,f,g}.
  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'h0: decode = 7'b0000001;
      4'h1: decode = 7'b1001111;
      4'h2: decode = 7'b0010010;
      4'h3: decode = 7'b0000110;
      4'h4: decode = 7'b1001100;
      4'h5: decode = 7'b0100100;
      4'h6: decode = 7'b0100000;
      4'h7: decode = 7'b0001111;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0000100;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b1100000;
      4'hC: decode = 7'b0110001;
      4'hD: decode = 7'b1000010;
      4'hE: decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  assign frame_start = (cnt == '0) && (dig == 2'd3);
  assign cur_char    = shadow[{dig, 2'b00} +: 4];

  // Slot counter, digit index and phase form the state. The output
  // registers are computed from the current state, so they trail the
  // counter by one cycle. Because every slot starts blank, the shadow
  // registers are always loaded before the first ON cycle reads them.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      dig        <= 2'd3;
      phase      <= BLANK;
      shadow     <= '0;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      frame_tick <= 1'b0;
`ifdef DISPLAY_DP_EN
      dp_shadow  <= 4'b0000;
      dp         <= 1'b1;
`endif
    end else begin
      frame_tick <= frame_start;
      if (frame_start) begin
        shadow <= {char_an3, char_an2, char_an1, char_an0};
`ifdef DISPLAY_DP_EN
        dp_shadow <= dp_in;
`endif
      end

      if (phase == ON) begin
        an  <= ~(4'b0001 << dig);
        seg <= decode(cur_char);
`ifdef DISPLAY_DP_EN
        dp  <= ~dp_shadow[dig];
`endif
      end else begin
        an  <= 4'b1111;
        seg <= 7'b1111111;
`ifdef DISPLAY_DP_EN
        dp  <= 1'b1;
`endif
      end

      // The digit index wraps 0 -> 3 through the natural 2-bit rollover.
      if (cnt == LAST_CNT) begin
        cnt   <= '0;
        dig   <= dig - 2'd1;
        phase <= BLANK;
      end else begin
        cnt <= cnt + 1'b1;
        if (cnt == DEAD_LAST) begin
          phase <= ON;
        end
      end
    end
  end

endmodule

// File: tb/tb_four_digit_display_driver.sv
// tb_four_digit_display_driver
//
// Purpose:
//   Self-checking bench for four_digit_display_driver with DIGIT_CYCLES=8
//   and DEAD_CYCLES=2. A timeline model predicts every output from the
//   cycle index since reset release and from the characters latched at
//   each frame start. Directed steps come first: reset, a mid-frame char
//   change, a sweep of char_an3 through all 16 values, and a one-cycle
//   reset in the middle of a frame. Randomised characters follow.
//
// Ports: none (top-level bench).

module tb_four_digit_display_driver;

  localparam int DC = 8;
  localparam int DD = 2;
  localparam int FR = 4 * DC;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] char_an0, char_an1, char_an2, char_an3;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_tick;
`ifdef DISPLAY_DP_EN
  logic [3:0] dp_in;
  logic       dp;
  logic [3:0] snapDp;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int t           = -1;
  logic [3:0] snap [4];

  logic [6:0] segTable [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  four_digit_display_driver #(
    .DIGIT_CYCLES(DC),
    .DEAD_CYCLES (DD),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .char_an0  (char_an0),
    .char_an1  (char_an1),
    .char_an2  (char_an2),
    .char_an3  (char_an3),
    .an        (an),
    .seg       (seg),
    .frame_tick(frame_tick)
`ifdef DISPLAY_DP_EN
    ,
    .dp_in     (dp_in),
    .dp        (dp)
`endif
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and reports it when the values differ.
  task automatic checkOne(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s at t=%0d: observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  // Expected outputs come from the cycle index since release: slot = t/8,
  // the digit runs 3,2,1,0, and the first two cycles of each slot are dark.
  task automatic checkOutput();
    logic [3:0] expAn;
    logic [6:0] expSeg;
    logic       expTick;
    logic       expDp;
    int         digit;
    int         offset;
    expAn   = 4'b1111;
    expSeg  = 7'b1111111;
    expTick = 1'b0;
    expDp   = 1'b1;
    if (t >= 0) begin
      offset  = t % DC;
      digit   = 3 - ((t / DC) % 4);
      expTick = ((t % FR) == 0);
      if (offset >= DD) begin
        expAn        = 4'b1111;
        expAn[digit] = 1'b0;
        expSeg       = segTable[snap[digit]];
`ifdef DISPLAY_DP_EN
        expDp        = ~snapDp[digit];
`endif
      end
    end
    checkOne("an", {12'd0, an}, {12'd0, expAn});
    checkOne("seg", {9'd0, seg}, {9'd0, expSeg});
    checkOne("frame_tick", {15'd0, frame_tick}, {15'd0, expTick});
    checkOne("an_onehot", {15'd0, ($countones(~an) <= 1)}, 16'd1);
`ifdef DISPLAY_DP_EN
    checkOne("dp", {15'd0, dp}, {15'd0, expDp});
`else
    if (expDp !== 1'b1) $display("[TB] unexpected dp model state");
`endif
  endtask

  // Drive one cycle of inputs, advance the model at the edge, and check
  // the outputs at the following falling edge.
  task automatic applyStimulus(input logic r, input logic [3:0] a3, input logic [3:0] a2,
                               input logic [3:0] a1, input logic [3:0] a0);
    reset    = r;
    char_an3 = a3;
    char_an2 = a2;
    char_an1 = a1;
    char_an0 = a0;
    @(posedge clk);
    if (r) begin
      t = -1;
    end else begin
      t++;
      if ((t % FR) == 0) begin
        snap[0] = a0;
        snap[1] = a1;
        snap[2] = a2;
        snap[3] = a3;
`ifdef DISPLAY_DP_EN
        snapDp  = dp_in;
`endif
      end
    end
    @(negedge clk);
    checkOutput();
  endtask

  logic [3:0] r0, r1, r2, r3;

  initial begin
    reset    = 1'b1;
    char_an0 = 4'd0;
    char_an1 = 4'd0;
    char_an2 = 4'd0;
    char_an3 = 4'd0;
    for (int k = 0; k < 4; k++) snap[k] = 4'd0;
`ifdef DISPLAY_DP_EN
    dp_in  = 4'b0101;
    snapDp = 4'b0000;
`endif
    $display("[TB] start");

    // Reset for three cycles, then chars 3,2,1,0 on an3..an0.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'd3, 4'd2, 4'd1, 4'd0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 4'd3, 4'd2, 4'd1, 4'd0);

    // char_an0 becomes F mid-frame; it must show only from the next frame.
    for (int i = 12; i < 64; i++) applyStimulus(1'b0, 4'd3, 4'd2, 4'd1, 4'hF);

    // Sweep char_an3 through every code, one frame each.
    for (int v = 0; v < 16; v++)
      for (int i = 0; i < FR; i++) applyStimulus(1'b0, 4'(v), 4'd2, 4'd1, 4'hF);

    // One-cycle reset in the middle of digit 1's ON window.
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 4'hA, 4'hB, 4'hC, 4'hD);
    applyStimulus(1'b1, 4'hA, 4'hB, 4'hC, 4'hD);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 4'h5, 4'h6, 4'h7, 4'h8);

    // Random characters, changing at random moments within the frame.
    r0 = 4'($urandom); r1 = 4'($urandom); r2 = 4'($urandom); r3 = 4'($urandom);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        r0 = 4'($urandom); r1 = 4'($urandom); r2 = 4'($urandom); r3 = 4'($urandom);
      end
`ifdef DISPLAY_DP_EN
      if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
`endif
      applyStimulus(1'b0, r3, r2, r1, r0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
